// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one outstanding bus transaction, address-error
// detection before issue, little-endian lane placement and load extraction/merge.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_rt,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] done_data,
    output logic        done_adel,
    output logic        done_ades,
    output logic [31:0] done_badvaddr
);
    localparam logic [3:0] OP_LB  = 4'd1,  OP_LBU = 4'd2,  OP_LH  = 4'd3,  OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5,  OP_LWL = 4'd6,  OP_LWR = 4'd7,  OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
    } req_t;

    state_t      state, nxt;
    req_t        req_q;
    logic [31:0] raw_q;
    logic        killed_q, adel_q, ades_q;
    logic        adel_c, ades_c, legal_c, resp_done, drop;
    logic [1:0]  a, na;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_res;

    always_comb begin
        adel_c  = 1'b0;
        ades_c  = 1'b0;
        legal_c = (in_op >= OP_LB) && (in_op <= OP_SWR);
        case (in_op)
            OP_LH, OP_LHU: adel_c = in_addr[0];
            OP_LW:         adel_c = |in_addr[1:0];
            OP_SH:         ades_c = in_addr[0];
            OP_SW:         ades_c = |in_addr[1:0];
            default: ;
        endcase
    end

    assign resp_done = ((state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                       ((state == S_WAIT) && dresp_data_ok);
    // A flush arriving in the completing cycle counts just like an earlier one.
    assign drop = killed_q | flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (in_valid) begin
                if (adel_c || ades_c || !legal_c) nxt = flush ? S_IDLE : S_DONE;
                else                              nxt = S_REQ;
            end
            S_REQ:  if (dresp_addr_ok) nxt = dresp_data_ok ? (drop ? S_IDLE : S_DONE) : S_WAIT;
            S_WAIT: if (dresp_data_ok) nxt = drop ? S_IDLE : S_DONE;
            S_DONE: if (done_ready || drop) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q    <= '0;
            raw_q    <= '0;
            killed_q <= 1'b0;
            adel_q   <= 1'b0;
            ades_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                req_q    <= '{op: in_op, addr: in_addr, rt: in_rt};
                adel_q   <= adel_c;
                ades_q   <= ades_c;
                killed_q <= flush;
            end else if (state != S_IDLE && flush) begin
                killed_q <= 1'b1;
            end
            if (resp_done) raw_q <= dresp_data;
        end
    end

    assign a  = req_q.addr[1:0];
    assign na = 2'd3 - a;

    always_comb begin
        dreq_valid  = (state == S_REQ);
        dreq_addr   = '0;
        dreq_size   = 2'd2;
        dreq_strobe = 4'b0000;
        dreq_data   = '0;
        if (state == S_REQ) begin
            // Unaligned-merge ops always talk to the containing word.
            if (req_q.op inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR}) dreq_addr = {req_q.addr[31:2], 2'b00};
            else                                                  dreq_addr = req_q.addr;
            case (req_q.op)
                OP_LB, OP_LBU: dreq_size = 2'd0;
                OP_LH, OP_LHU: dreq_size = 2'd1;
                OP_SB: begin
                    dreq_size   = 2'd0;
                    dreq_strobe = 4'b0001 << a;
                    dreq_data   = {4{req_q.rt[7:0]}};
                end
                OP_SH: begin
                    dreq_size   = 2'd1;
                    dreq_strobe = a[1] ? 4'b1100 : 4'b0011;
                    dreq_data   = {2{req_q.rt[15:0]}};
                end
                OP_SW: begin
                    dreq_strobe = 4'b1111;
                    dreq_data   = req_q.rt;
                end
                OP_SWL: begin
                    dreq_strobe = 4'b1111 >> na;
                    dreq_data   = req_q.rt >> {na, 3'b000};
                end
                OP_SWR: begin
                    dreq_strobe = 4'b1111 << a;
                    dreq_data   = req_q.rt << {a, 3'b000};
                end
                default: ;
            endcase
        end
    end

    assign byte_sel = raw_q[{a, 3'b000} +: 8];
    assign half_sel = a[1] ? raw_q[31:16] : raw_q[15:0];

    always_comb begin
        load_res = '0;
        case (req_q.op)
            OP_LB:  load_res = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_res = {24'h0, byte_sel};
            OP_LH:  load_res = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_res = {16'h0, half_sel};
            OP_LW:  load_res = raw_q;
            OP_LWL: case (a)
                2'd0: load_res = {raw_q[7:0],  req_q.rt[23:0]};
                2'd1: load_res = {raw_q[15:0], req_q.rt[15:0]};
                2'd2: load_res = {raw_q[23:0], req_q.rt[7:0]};
                default: load_res = raw_q;
            endcase
            OP_LWR: case (a)
                2'd0: load_res = raw_q;
                2'd1: load_res = {req_q.rt[31:24], raw_q[31:8]};
                2'd2: load_res = {req_q.rt[31:16], raw_q[31:16]};
                default: load_res = {req_q.rt[31:8], raw_q[31:24]};
            endcase
            default: ;
        endcase
    end

    assign in_ready      = (state == S_IDLE);
    assign done_valid    = (state == S_DONE);
    assign done_adel     = done_valid & adel_q;
    assign done_ades     = done_valid & ades_q;
    assign done_data     = (done_valid && !adel_q && !ades_q) ? load_res : '0;
    assign done_badvaddr = (done_valid && (adel_q || ades_q)) ? req_q.addr : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: byte-level reference model, bus/writeback
// responders with random stalls, and a per-cycle output compare process.
module tb_mem_access_unit;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0, in_rt = '0;
    logic        in_ready, dreq_valid, done_valid, done_adel, done_ades;
    logic [31:0] dreq_addr, dreq_data, done_data, done_badvaddr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0, done_ready = 1'b0;
    logic [31:0] dresp_data = '0;

    mem_access_unit dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_rt(in_rt), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
        .done_adel(done_adel), .done_ades(done_ades), .done_badvaddr(done_badvaddr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bus;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } exp_t;

    int   checks = 0, errors = 0;
    exp_t ex;
    bit   chk_en = 0, exp_kill = 0;
    int   o_dreq_cyc, o_done_cyc, o_done_cnt;
    logic [31:0] o_data, o_dreq_addr, o_wdata, o_bad;
    logic [3:0]  o_strb;
    logic        o_adel, o_ades;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: byte-array view of the memory word and rt, lanes indexed 0..3.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr, rt, mem);
        exp_t e;
        int a;
        logic [7:0] mb[4], rb[4], res[4], ln[4];
        e = '0;
        a = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            mb[i] = mem[8*i +: 8]; rb[i] = rt[8*i +: 8]; res[i] = rb[i]; ln[i] = 8'h0;
        end
        if (op == 4'd0 || op > 4'd12) return e;
        if (((op == 4'd3 || op == 4'd4) && addr[0]) || (op == 4'd5 && a != 0)) begin
            e.adel = 1'b1; e.bad = addr; return e;
        end
        if ((op == 4'd9 && addr[0]) || (op == 4'd10 && a != 0)) begin
            e.ades = 1'b1; e.bad = addr; return e;
        end
        e.bus  = 1'b1;
        e.addr = (op inside {4'd6, 4'd7, 4'd11, 4'd12}) ? {addr[31:2], 2'b00} : addr;
        e.size = (op inside {4'd1, 4'd2, 4'd8}) ? 2'd0 : (op inside {4'd3, 4'd4, 4'd9}) ? 2'd1 : 2'd2;
        case (op)
            4'd1: e.data = {{24{mb[a][7]}}, mb[a]};
            4'd2: e.data = {24'h0, mb[a]};
            4'd3: e.data = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
            4'd4: e.data = {16'h0, mb[a+1], mb[a]};
            4'd5: e.data = mem;
            4'd6: begin
                for (int i = 0; i <= a; i++) res[3-a+i] = mb[i];
                e.data = {res[3], res[2], res[1], res[0]};
            end
            4'd7: begin
                for (int i = a; i < 4; i++) res[i-a] = mb[i];
                e.data = {res[3], res[2], res[1], res[0]};
            end
            4'd8:  begin e.strb[a] = 1'b1; for (int i = 0; i < 4; i++) ln[i] = rb[0]; end
            4'd9:  begin e.strb[a] = 1'b1; e.strb[a+1] = 1'b1; for (int i = 0; i < 4; i++) ln[i] = rb[i%2]; end
            4'd10: begin e.strb = 4'hF; for (int i = 0; i < 4; i++) ln[i] = rb[i]; end
            4'd11: for (int i = 0; i <= a; i++) begin e.strb[i] = 1'b1; ln[i] = rb[3-a+i]; end
            default: for (int i = a; i < 4; i++) begin e.strb[i] = 1'b1; ln[i] = rb[i-a]; end
        endcase
        e.wdata = {ln[3], ln[2], ln[1], ln[0]};
        return e;
    endfunction

    // Per-cycle compare of every meaningful DUT output against the model.
    always @(negedge clk) if (chk_en && resetn) begin
        if (dreq_valid) begin
            chk("dreq_expected", 32'(ex.bus), 32'd1);
            chk("dreq_addr", dreq_addr, ex.addr);
            chk("dreq_size", 32'(dreq_size), 32'(ex.size));
            chk("dreq_strobe", 32'(dreq_strobe), 32'(ex.strb));
            if (ex.strb != 4'h0) chk("dreq_data", dreq_data, ex.wdata);
        end
        if (done_valid) begin
            chk("done_after_kill", 32'(exp_kill), 32'd0);
            chk("done_data", done_data, ex.data);
            chk("done_adel", 32'(done_adel), 32'(ex.adel));
            chk("done_ades", 32'(done_ades), 32'(ex.ades));
            chk("done_badvaddr", done_badvaddr, ex.bad);
        end
    end

    // ad: dreq cycles before addr_ok; dd: cycles from addr_ok to data_ok; rd: done stall.
    task automatic run(input logic [3:0] op, input logic [31:0] addr, rt, mem,
                       input int ad, dd, rd, input bit fl_in);
        int n, rq, dc, held, ph;
        bit fin, fl;
        ex = model(op, addr, rt, mem);
        fl = fl_in && ex.bus && dd >= 1;
        exp_kill = 0;
        o_dreq_cyc = -1; o_done_cyc = -1; o_done_cnt = 0;
        n = 0; rq = 0; dc = 0; held = 0; ph = 0; fin = 0;
        @(posedge clk); #1;
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_rt = rt;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 4'($urandom_range(0, 15)); in_addr = $urandom(); in_rt = $urandom();
        while (!fin && n < 200) begin
            @(negedge clk); n++;
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; done_ready = 1'b0; flush = 1'b0;
            dresp_data = $urandom();
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            if (dreq_valid && o_dreq_cyc < 0) begin
                o_dreq_cyc = n; o_dreq_addr = dreq_addr; o_strb = dreq_strobe; o_wdata = dreq_data;
            end
            if (done_valid) begin
                if (o_done_cyc < 0) o_done_cyc = n;
                o_data = done_data; o_adel = done_adel; o_ades = done_ades; o_bad = done_badvaddr;
                o_done_cnt++;
                if (held == rd) begin done_ready = 1'b1; fin = 1; end
                held++;
            end
            if (ph == 0 && dreq_valid) begin
                if (rq == ad) begin
                    dresp_addr_ok = 1'b1;
                    if (dd == 0) begin
                        dresp_data_ok = 1'b1; dresp_data = mem; ph = 2;
                    end else ph = 1;
                end else rq++;
            end else if (ph == 1) begin
                dc++;
                if (fl && dc == 1) begin flush = 1'b1; exp_kill = 1; end
                if (dc >= dd) begin
                    dresp_data_ok = 1'b1; dresp_data = mem; ph = 2;
                    if (exp_kill) fin = 1;
                end
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL timeout op=%0d addr=%h actual=stuck required=completion", op, addr);
        end
        @(negedge clk);
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; done_ready = 1'b0; flush = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_done_valid", 32'(done_valid), 32'd0);
        chk("idle_dreq_valid", 32'(dreq_valid), 32'd0);
        if (!ex.bus) chk("no_bus_activity", 32'(o_dreq_cyc), 32'hFFFF_FFFF);
        else         chk("dreq_latency", 32'(o_dreq_cyc), 32'd1);
        if (exp_kill) chk("killed_no_done", 32'(o_done_cnt), 32'd0);
        else          chk("done_hold_cycles", 32'(o_done_cnt), 32'(rd + 1));
        if (!fin) begin
            resetn = 1'b0; #2 resetn = 1'b1;
        end
    endtask

    initial begin
        exp_t t;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
        chk("rst_dreq_addr", dreq_addr, 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_data", done_data, 32'd0);
        chk("rst_badvaddr", done_badvaddr, 32'd0);
        @(negedge clk); resetn = 1'b1; chk_en = 1;

        t = model(4'd6, 32'h4000_0001, 32'hAABB_CCDD, 32'h1122_3344);
        chk("model_lwl", t.data, 32'h3344_CCDD);
        t = model(4'd12, 32'h4000_0002, 32'h1234_5678, 32'h0);
        chk("model_swr", t.wdata, 32'h5678_0000);

        run(4'd1, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
        chk("lb_data", o_data, 32'hFFFF_FF80);
        chk("lb_done_latency", 32'(o_done_cyc), 32'd2);
        run(4'd2, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, 0);
        chk("lbu_data", o_data, 32'h0000_0080);
        run(4'd5, 32'h1000_0002, 32'h0, 32'h0, 0, 0, 0, 0);
        chk("lw_adel", 32'(o_adel), 32'd1);
        chk("lw_badvaddr", o_bad, 32'h1000_0002);
        chk("exc_done_latency", 32'(o_done_cyc), 32'd1);
        run(4'd9, 32'h1000_0001, 32'h55, 32'h0, 0, 0, 0, 0);
        chk("sh_ades", 32'(o_ades), 32'd1);
        run(4'd6, 32'h4000_0001, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 0, 0);
        chk("lwl_dreq_addr", o_dreq_addr, 32'h4000_0000);
        chk("lwl_data", o_data, 32'h3344_CCDD);
        run(4'd7, 32'h4000_0001, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 0, 0);
        chk("lwr_data", o_data, 32'hAA11_2233);
        run(4'd12, 32'h4000_0002, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
        chk("swr_strobe", 32'(o_strb), 32'h0000_000C);
        chk("swr_wdata", o_wdata, 32'h5678_0000);
        run(4'd8, 32'h4000_0003, 32'h0000_00EF, 32'h0, 0, 0, 0, 0);
        chk("sb_strobe", 32'(o_strb), 32'h0000_0008);
        chk("sb_wdata", o_wdata, 32'hEFEF_EFEF);
        chk("store_done_data", o_data, 32'h0);
        run(4'd5, 32'h4000_0008, 32'h0, 32'hCAFE_F00D, 3, 2, 4, 0);
        chk("stall_lw_data", o_data, 32'hCAFE_F00D);
        run(4'd5, 32'h4000_000C, 32'h0, 32'h1234_0000, 0, 3, 0, 1);
        chk("flush_in_wait", 32'(exp_kill), 32'd1);
        run(4'd15, 32'h4000_0010, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
        chk("illegal_data", o_data, 32'h0);

        // Async reset while a request is outstanding.
        ex = model(4'd5, 32'h2000_0000, 32'h0, 32'h0);
        @(posedge clk); #1 in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h2000_0000;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rstreq_dreq_before", 32'(dreq_valid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rstreq_dreq_after", 32'(dreq_valid), 32'd0);
        chk("rstreq_in_ready", 32'(in_ready), 32'd1);
        chk("rstreq_done_valid", 32'(done_valid), 32'd0);
        @(negedge clk); resetn = 1'b1;

        for (int k = 0; k < 200; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(1, 12));
            run(op, $urandom(), $urandom(), $urandom(), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
